gf180mcu_osu_sc_gp12t3v3__clken_seq: RTL and testbench
======================================================

# gf180mcu_osu_sc_gp12t3v3__clken_seq

Staggered clock-branch enable sequencer for the 12-track 3.3 V library. It drives the enables of N gated clock-tree branches built from the clkbuf cells, each feeding a clock-gate cell. It moves the branch-enable vector toward a requested mask one bit at a time, with a programmable gap between changes, so no two branches switch in the same cycle and supply di/dt stays bounded. Disables are applied before enables.

## Interface
- N, default 4: number of clock branches.
- GAP_W, default 4: width of the stagger-gap field.

- CLK  input  1  sequencer clock; an ungated, always-running branch.
- RN  input  1  asynchronous active-low reset.
- REQ_EN  input  N  requested branch-enable mask; level, sampled only in IDLE.
- GAP  input  GAP_W  extra idle cycles between successive EN changes; sampled with REQ_EN.
- EN  output  N  registered branch enables driving the clock-gate enable pins.
- BUSY  output  1  high while a sequence is in progress.
- DONE  output  1  one-cycle pulse on the edge that applies the last change of a sequence.

## Operation
- Reset: while RN is low, EN=0, BUSY=0, DONE=0, state=IDLE, and internal TGT, GAPQ and CNT are all 0.
- States: IDLE, STEP, WAIT.
- IDLE
  - If REQ_EN != EN on an edge: TGT<=REQ_EN, GAPQ<=GAP, BUSY<=1, go to STEP.
  - Otherwise remain in IDLE. DONE is 0 on every IDLE edge except the exit edge of a sequence.
- STEP: flip exactly one EN bit, selected as follows.
  - If any bit has EN=1 and TGT=0, clear the lowest-index such bit.
  - Otherwise set the lowest-index bit with EN=0 and TGT=1.
- After the flip:
  - If EN now equals TGT: go to IDLE, BUSY<=0, DONE<=1 for one cycle.
  - Else if GAPQ=0: stay in STEP.
  - Else: CNT<=GAPQ-1, go to WAIT.
- WAIT: if CNT=0, go to STEP; otherwise CNT<=CNT-1.
- REQ_EN and GAP changes while BUSY=1 are ignored. The TGT and GAPQ latched at acceptance govern the whole sequence.
- After DONE, IDLE re-compares REQ_EN with EN on the next edge. A pending new mask starts a new sequence from the current EN.
- REQ_EN equal to EN in IDLE: no action and no DONE.
- An empty mask is legal and disables all branches one by one, lowest index first.

## Timing
- Let edge k be the edge on which IDLE accepts a request (BUSY rises at k).
- With m bits differing, the changes occur at edges k+1+i·(GAPQ+1), for i=0..m-1.
- The last change occurs at edge k+1+(m-1)(GAPQ+1). BUSY falls and DONE rises at that same edge; DONE falls one edge later.
- Exactly one EN bit toggles per change edge. EN, BUSY and DONE are all register outputs with no combinational path from inputs.
- Earliest next acceptance is at last-change edge +1.
- Asynchronous reset mid-sequence forces EN=0 immediately. Sequencing resumes from EN=0 after RN deasserts, on the first edge that sees REQ_EN != 0.

## Test plan
- Reset: assert RN low during any state → EN=0000, BUSY=0, DONE=0 within the same cycle; they hold these values through release.
- Enable ramp: EN=0000, GAP=2, REQ_EN=1011 accepted at edge k → EN=0001@k+1, 0011@k+4, 1011@k+7; BUSY high k..k+6; DONE high for exactly edge k+7.
- Disable-first ordering: EN=1011, GAP=0, REQ_EN=0110 → EN=1010@k+1, 0010@k+2, 0110@k+3; DONE@k+3; no cycle has two bits changing.
- Mid-sequence input change: during the ramp above, set REQ_EN=0000 and GAP=0 at k+2 → ramp completes to 1011 at the original edges. At k+8 IDLE accepts the new request; EN=1010@k+9, 1000@k+10, 0000@k+11; DONE@k+11.
- No-op: REQ_EN equal to EN in IDLE for 20 cycles → BUSY and DONE stay 0 and EN is unchanged.
- Reset mid-sequence: pull RN low at k+5 of the ramp → EN=0000 asynchronously. Release with REQ_EN=1011 → full ramp restarts from 0000 with the same spacing.

Source files
------------

// File: rtl/gf180mcu_osu_sc_gp12t3v3__clken_seq_if.sv
// Purpose : request/status bundle between a controller and the clock-branch enable sequencer.
// Latency : none, this file only groups wires.
// Backpressure: none; REQ_EN/GAP are levels and are sampled only while the sequencer is idle.
// Ports   : REQ_EN/GAP requested mask and stagger gap; EN/BUSY/DONE sequencer status.
interface gf180mcu_osu_sc_gp12t3v3__clken_seq_if #(
   parameter int N     = 4,
   parameter int GAP_W = 4
);
   logic [N-1:0]     REQ_EN;
   logic [GAP_W-1:0] GAP;
   logic [N-1:0]     EN;
   logic             BUSY;
   logic             DONE;

   modport master (output REQ_EN, GAP, input EN, BUSY, DONE);
   modport slave  (input REQ_EN, GAP, output EN, BUSY, DONE);
endinterface

// File: rtl/gf180mcu_osu_sc_gp12t3v3__clken_seq.sv
// Purpose : walks the clock-branch enable vector toward a requested mask one bit per change,
//           disables before enables, with GAP idle cycles between changes to bound di/dt.
// Latency : first change one edge after acceptance, then one change every GAP+1 edges.
// Backpressure: new requests are ignored while BUSY; IDLE re-samples REQ_EN on every edge.
// Ports   : CLK ungated sequencer clock, RN async active-low reset,
//           bus.REQ_EN/bus.GAP request in, bus.EN/bus.BUSY/bus.DONE registered outputs.
module gf180mcu_osu_sc_gp12t3v3__clken_seq #(
   parameter int N     = 4,
   parameter int GAP_W = 4
) (
   input  logic CLK,
   input  logic RN,
   gf180mcu_osu_sc_gp12t3v3__clken_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE, STEP, WAIT} state_t;

   localparam logic [N-1:0]     ONE_N = N'(1);
   localparam logic [GAP_W-1:0] ONE_G = GAP_W'(1);

   state_t           state_q, state_d;
   logic [N-1:0]     en_q, en_d;
   logic [N-1:0]     tgt_q, tgt_d;
   logic [GAP_W-1:0] gapq_q, gapq_d;
   logic [GAP_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [N-1:0]     clr_mask;
   logic [N-1:0]     set_mask;
   logic [N-1:0]     pick;
   logic [N-1:0]     en_flip;

   // Bits still to be cleared take priority over bits to be set; x & -x isolates
   // the lowest-index set bit of each candidate mask.
   always_comb begin
      clr_mask = en_q & ~tgt_q;
      set_mask = ~en_q & tgt_q;
      if (|clr_mask) begin
         pick = clr_mask & (~clr_mask + ONE_N);
      end else begin
         pick = set_mask & (~set_mask + ONE_N);
      end
      en_flip = en_q ^ pick;
   end

   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      tgt_d   = tgt_q;
      gapq_d  = gapq_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.REQ_EN != en_q) begin
               tgt_d   = bus.REQ_EN;
               gapq_d  = bus.GAP;
               busy_d  = 1'b1;
               state_d = STEP;
            end
         end
         STEP: begin
            en_d = en_flip;
            if (en_flip == tgt_q) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (gapq_q != '0) begin
               // WAIT spends GAPQ edges in total: GAPQ-1 down to 0 inclusive.
               cnt_d   = gapq_q - ONE_G;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = STEP;
            end else begin
               cnt_d = cnt_q - ONE_G;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q <= IDLE;
         en_q    <= '0;
         tgt_q   <= '0;
         gapq_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         tgt_q   <= tgt_d;
         gapq_q  <= gapq_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.EN   = en_q;
   assign bus.BUSY = busy_q;
   assign bus.DONE = done_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__clken_seq.sv
// Purpose : self-checking bench for the clock-branch enable sequencer.
// Latency : n/a.
// Backpressure: n/a.
module tb_gf180mcu_osu_sc_gp12t3v3__clken_seq;

   localparam int N     = 4;
   localparam int GAP_W = 4;

   logic CLK;
   logic RN;

   gf180mcu_osu_sc_gp12t3v3__clken_seq_if #(.N(N), .GAP_W(GAP_W)) bus ();

   gf180mcu_osu_sc_gp12t3v3__clken_seq #(.N(N), .GAP_W(GAP_W)) dut (
      .CLK (CLK),
      .RN  (RN),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int vectors;
   int miscompares;

   // Reference model: on acceptance, the whole sequence is laid out as an ordered
   // list of bit indices to toggle (clears ascending, then sets ascending); one is
   // consumed every GAP+1 edges.
   logic [N-1:0] m_en;
   logic         m_busy;
   logic         m_done;
   int           m_gap;
   int           m_wait;
   int           m_q[$];

   task automatic model_reset();
      m_en   = '0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_gap  = 0;
      m_wait = 0;
      m_q.delete();
   endtask

   task automatic model_edge();
      int b;
      m_done = 1'b0;
      if (m_busy) begin
         if (m_wait == 0) begin
            b = m_q.pop_front();
            m_en[b] = ~m_en[b];
            if (m_q.size() == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end else begin
               m_wait = m_gap;
            end
         end else begin
            m_wait = m_wait - 1;
         end
      end else if (bus.REQ_EN != m_en) begin
         for (int i = 0; i < N; i++) if (m_en[i] && !bus.REQ_EN[i]) m_q.push_back(i);
         for (int i = 0; i < N; i++) if (!m_en[i] && bus.REQ_EN[i]) m_q.push_back(i);
         m_gap  = int'(bus.GAP);
         m_wait = 0;
         m_busy = 1'b1;
      end
   endtask

   // One clock: model follows the active edge, then control returns on the falling
   // edge where outputs are sampled and inputs may be changed.
   task automatic tick();
      @(posedge CLK);
      if (RN) model_edge();
      @(negedge CLK);
   endtask

   task automatic test_reset();
      RN = 1'b0;
      bus.REQ_EN = 4'b1111;
      bus.GAP = 4'd1;
      model_reset();
      #1;
      for (int c = 0; c < 4; c++) begin
         vectors++;
         if ({bus.EN, bus.BUSY, bus.DONE} !== {4'b0000, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset cyc%0d: got EN=%b BUSY=%b DONE=%b, want 0000/0/0", c, bus.EN, bus.BUSY, bus.DONE);
         end
         tick();
      end
      bus.REQ_EN = 4'b0000;
      RN = 1'b1;
      tick();
      vectors++;
      if ({bus.EN, bus.BUSY, bus.DONE} !== {4'b0000, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_release: got EN=%b BUSY=%b DONE=%b, want 0000/0/0", bus.EN, bus.BUSY, bus.DONE);
      end
   endtask

   // Ramp to 1011 with GAP=2, while the request is changed mid-sequence to 0000/GAP=0.
   task automatic test_ramp_mid_change();
      logic [3:0]  exp_en [12];
      logic [11:0] exp_busy;
      logic [11:0] exp_done;
      exp_en[0] = 4'b0000; exp_en[1]  = 4'b0001; exp_en[2]  = 4'b0001; exp_en[3]  = 4'b0001;
      exp_en[4] = 4'b0011; exp_en[5]  = 4'b0011; exp_en[6]  = 4'b0011; exp_en[7]  = 4'b1011;
      exp_en[8] = 4'b1011; exp_en[9]  = 4'b1010; exp_en[10] = 4'b1000; exp_en[11] = 4'b0000;
      exp_busy = 12'b0111_0111_1111;   // bit i = edge k+i
      exp_done = 12'b1000_1000_0000;
      bus.REQ_EN = 4'b1011;
      bus.GAP = 4'd2;
      for (int i = 0; i < 12; i++) begin
         tick();
         vectors++;
         if ({bus.EN, bus.BUSY, bus.DONE} !== {exp_en[i], exp_busy[i], exp_done[i]}) begin
            miscompares++;
            $display("FAIL ramp k+%0d: got EN=%b BUSY=%b DONE=%b, want EN=%b BUSY=%b DONE=%b",
                     i, bus.EN, bus.BUSY, bus.DONE, exp_en[i], exp_busy[i], exp_done[i]);
         end
         vectors++;
         if ({bus.EN, bus.BUSY, bus.DONE} !== {m_en, m_busy, m_done}) begin
            miscompares++;
            $display("FAIL ramp_model k+%0d: got EN=%b BUSY=%b DONE=%b, want EN=%b BUSY=%b DONE=%b",
                     i, bus.EN, bus.BUSY, bus.DONE, m_en, m_busy, m_done);
         end
         if (i == 2) begin
            bus.REQ_EN = 4'b0000;
            bus.GAP = 4'd0;
         end
      end
   endtask

   task automatic test_disable_first();
      logic [3:0] exp_en [4];
      logic [3:0] prev;
      int guard;
      exp_en[0] = 4'b1011; exp_en[1] = 4'b1010; exp_en[2] = 4'b0010; exp_en[3] = 4'b0110;
      bus.REQ_EN = 4'b1011;
      bus.GAP = 4'd0;
      guard = 0;
      do begin
         tick();
         guard++;
      end while ((m_busy || m_en != 4'b1011) && guard < 50);
      vectors++;
      if (bus.EN !== 4'b1011 || guard >= 50) begin
         miscompares++;
         $display("FAIL dis_setup: got EN=%b after %0d cycles, want 1011", bus.EN, guard);
      end
      bus.REQ_EN = 4'b0110;
      prev = bus.EN;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if ({bus.EN, bus.BUSY, bus.DONE} !== {exp_en[i], (i != 3), (i == 3)}) begin
            miscompares++;
            $display("FAIL dis_first k+%0d: got EN=%b BUSY=%b DONE=%b, want EN=%b BUSY=%b DONE=%b",
                     i, bus.EN, bus.BUSY, bus.DONE, exp_en[i], (i != 3), (i == 3));
         end
         vectors++;
         if ($countones(bus.EN ^ prev) > 1) begin
            miscompares++;
            $display("FAIL dis_onebit k+%0d: got %0d bits changed, want <=1", i, $countones(bus.EN ^ prev));
         end
         prev = bus.EN;
      end
   endtask

   task automatic test_noop();
      tick();
      bus.REQ_EN = m_en;
      for (int c = 0; c < 20; c++) begin
         tick();
         vectors++;
         if ({bus.EN, bus.BUSY, bus.DONE} !== {4'b0110, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL noop cyc%0d: got EN=%b BUSY=%b DONE=%b, want 0110/0/0", c, bus.EN, bus.BUSY, bus.DONE);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] exp_en [8];
      exp_en[0] = 4'b0000; exp_en[1] = 4'b0001; exp_en[2] = 4'b0001; exp_en[3] = 4'b0001;
      exp_en[4] = 4'b0011; exp_en[5] = 4'b0011; exp_en[6] = 4'b0011; exp_en[7] = 4'b1011;
      RN = 1'b0;
      model_reset();
      bus.REQ_EN = 4'b1011;
      bus.GAP = 4'd2;
      tick();
      RN = 1'b1;
      for (int i = 0; i <= 5; i++) tick();
      vectors++;
      if (bus.EN !== 4'b0011 || bus.BUSY !== 1'b1) begin
         miscompares++;
         $display("FAIL rmid_pre: got EN=%b BUSY=%b, want 0011/1", bus.EN, bus.BUSY);
      end
      #2;
      RN = 1'b0;
      model_reset();
      #1;
      vectors++;
      if ({bus.EN, bus.BUSY, bus.DONE} !== {4'b0000, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL rmid_async: got EN=%b BUSY=%b DONE=%b, want 0000/0/0", bus.EN, bus.BUSY, bus.DONE);
      end
      @(negedge CLK);
      RN = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         vectors++;
         if ({bus.EN, bus.BUSY, bus.DONE} !== {exp_en[i], (i != 7), (i == 7)}) begin
            miscompares++;
            $display("FAIL rmid_ramp k+%0d: got EN=%b BUSY=%b DONE=%b, want EN=%b BUSY=%b DONE=%b",
                     i, bus.EN, bus.BUSY, bus.DONE, exp_en[i], (i != 7), (i == 7));
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] prev;
      prev = bus.EN;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.REQ_EN = 4'($urandom);
            bus.GAP = 4'($urandom_range(0, 3));
         end
         tick();
         vectors++;
         if ({bus.EN, bus.BUSY, bus.DONE} !== {m_en, m_busy, m_done}) begin
            miscompares++;
            $display("FAIL rand cyc%0d: got EN=%b BUSY=%b DONE=%b, want EN=%b BUSY=%b DONE=%b",
                     c, bus.EN, bus.BUSY, bus.DONE, m_en, m_busy, m_done);
         end
         vectors++;
         if ($countones(bus.EN ^ prev) > 1) begin
            miscompares++;
            $display("FAIL rand_onebit cyc%0d: got %0d bits changed, want <=1", c, $countones(bus.EN ^ prev));
         end
         prev = bus.EN;
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      RN = 1'b0;
      bus.REQ_EN = '0;
      bus.GAP = '0;
      model_reset();
      @(negedge CLK);
      test_reset();
      test_ramp_mid_change();
      test_disable_first();
      test_noop();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
